// File: rtl/biu_constants_pkg.sv
// rtl/biu_constants_pkg.sv - shared bus-interface types and helpers for the data-memory responder
// Contents:
//   biu_size_t     access size carried on dmem_size (BYTE/HWORD/WORD/DWORD)
//   dmem_state_t   responder FSM states
//   lane_mask()    byte-enable decode from size and address low bits
//   is_misaligned() alignment check from size and address low bits
package biu_constants_pkg;

   typedef enum logic [1:0] {
      BIU_BYTE  = 2'd0,
      BIU_HWORD = 2'd1,
      BIU_WORD  = 2'd2,
      BIU_DWORD = 2'd3
   } biu_size_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_t;

   function automatic logic [3:0] lane_mask(input biu_size_t size, input logic [1:0] lo);
      logic [3:0] m;
      case (size)
         BIU_BYTE:  m = 4'b0001 << lo;
         BIU_HWORD: m = lo[1] ? 4'b1100 : 4'b0011;
         BIU_WORD:  m = 4'b1111;
         default:   m = 4'b0000;
      endcase
      return m;
   endfunction

   // DWORD cannot be served by a 32-bit word array, so it always reports misaligned.
   function automatic logic is_misaligned(input biu_size_t size, input logic [1:0] lo);
      logic r;
      case (size)
         BIU_BYTE:  r = 1'b0;
         BIU_HWORD: r = lo[0];
         BIU_WORD:  r = (lo != 2'b00);
         default:   r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_ram_1rw.sv
// rtl/dmem_ram_1rw.sv - single-port word RAM with per-byte write enables
// Ports:
//   clk    write clock
//   we     write strobe
//   be     byte-lane enables for the write
//   addr   word address (shared by read and write)
//   wdata  write data
//   rdata  asynchronous read data of the addressed word
// The array has no reset; contents survive the responder's reset.
module dmem_ram_1rw #(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - core data-memory responder with fixed latency over a local word array
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   dmem_req/adr/d/we/size         request from the core, sampled only in IDLE
//   dmem_q                         full aligned read word, nonzero only with a read ack
//   dmem_ack/err/misaligned        one-cycle response strobes, exactly one per transaction
//   dmem_page_fault                tied low
// BASE_ADDR is expected to be word aligned.
module dmem_responder
   import biu_constants_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter int          MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter int          LATENCY   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            dmem_req,
   input  logic [XLEN-1:0] dmem_adr,
   input  logic [XLEN-1:0] dmem_d,
   input  logic            dmem_we,
   input  biu_size_t       dmem_size,
   output logic [XLEN-1:0] dmem_q,
   output logic            dmem_ack,
   output logic            dmem_err,
   output logic            dmem_misaligned,
   output logic            dmem_page_fault
);

   localparam int         AW     = $clog2(MEM_WORDS);
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   dmem_state_t     state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] adr_q, adr_d, d_q, d_d, q_q, q_d;
   logic            we_q, we_d;
   biu_size_t       size_q, size_d;
   logic            ack_q, ack_d, err_q, err_d, mis_q, mis_d;

   logic [XLEN-1:0] t_adr, t_d, wdata, rdata;
   logic [XLEN-3:0] word_idx;
   logic            t_we, t_mis, t_err, resp_go, ram_we;
   biu_size_t       t_size;
   logic [3:0]      be;

   // With LATENCY=1 the response is registered on the accept edge itself,
   // so the live request is used in IDLE and the captured copy afterwards.
   always_comb begin
      t_adr    = (state_q == ST_IDLE) ? dmem_adr  : adr_q;
      t_d      = (state_q == ST_IDLE) ? dmem_d    : d_q;
      t_we     = (state_q == ST_IDLE) ? dmem_we   : we_q;
      t_size   = (state_q == ST_IDLE) ? dmem_size : size_q;
      word_idx = t_adr[XLEN-1:2] - BASE_ADDR[XLEN-1:2];
      t_mis    = is_misaligned(t_size, t_adr[1:0]);
      t_err    = (t_adr < BASE_ADDR) || (word_idx >= (XLEN-2)'(MEM_WORDS));
      be       = lane_mask(t_size, t_adr[1:0]);
      // Sub-word write data arrives in the low bits; replicate it so the
      // lane mask selects the copy sitting in the addressed lane(s).
      case (t_size)
         BIU_BYTE:  wdata = {4{t_d[7:0]}};
         BIU_HWORD: wdata = {2{t_d[15:0]}};
         default:   wdata = t_d;
      endcase
      resp_go = ((state_q == ST_IDLE) && dmem_req && (LATENCY == 1)) ||
                ((state_q == ST_WAIT) && (cnt_q == 4'd1));
      ram_we  = resp_go && t_we && !t_mis && !t_err;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      d_d     = d_q;
      we_d    = we_q;
      size_d  = size_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mis_d   = 1'b0;
      q_d     = '0;
      case (state_q)
         ST_IDLE: begin
            if (dmem_req) begin
               adr_d  = dmem_adr;
               d_d    = dmem_d;
               we_d   = dmem_we;
               size_d = dmem_size;
               if (LATENCY == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         ST_WAIT: begin
            // Leave WAIT on the edge where the counter reaches zero.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Strobes are registered on the edge entering RESP, so they are
      // visible for exactly the RESP cycle.
      if (resp_go) begin
         mis_d = t_mis;
         err_d = !t_mis && t_err;
         ack_d = !t_mis && !t_err;
         if (!t_mis && !t_err && !t_we) begin
            q_d = rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         adr_q   <= '0;
         d_q     <= '0;
         we_q    <= 1'b0;
         size_q  <= BIU_BYTE;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         mis_q   <= 1'b0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         d_q     <= d_d;
         we_q    <= we_d;
         size_q  <= size_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         q_q     <= q_d;
      end
   end

   dmem_ram_1rw #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .be    (be),
      .addr  (word_idx[AW-1:0]),
      .wdata (wdata),
      .rdata (rdata)
   );

   assign dmem_q          = q_q;
   assign dmem_ack        = ack_q;
   assign dmem_err        = err_q;
   assign dmem_misaligned = mis_q;
   assign dmem_page_fault = 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY 1 and 3 instances)
module tb_dmem_responder;
   import biu_constants_pkg::*;

   localparam logic [2:0] R_ACK = 3'b100;
   localparam logic [2:0] R_ERR = 3'b010;
   localparam logic [2:0] R_MIS = 3'b001;

   typedef struct {
      logic        we;
      biu_size_t   sz;
      logic [31:0] adr;
      logic [31:0] d;
      logic [2:0]  res;
      logic [31:0] q;
   } vec_t;

   typedef struct {
      logic [2:0]  res;
      logic [31:0] q;
      int          cyc;
      int          tag;
   } exp_t;

   logic        clk, rst;
   logic        a_req, a_we, a_ack, a_err, a_mis, a_pf;
   logic [31:0] a_adr, a_d, a_q;
   biu_size_t   a_size;
   logic        b_req, b_we, b_ack, b_err, b_mis, b_pf;
   logic [31:0] b_adr, b_d, b_q;
   biu_size_t   b_size;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t qa[$];
   exp_t qb[$];
   vec_t ta[$];
   vec_t tb_v[$];

   dmem_responder #(.XLEN(32), .MEM_WORDS(64), .BASE_ADDR(32'h0), .LATENCY(1)) dut_a (
      .clk(clk), .rst(rst), .dmem_req(a_req), .dmem_adr(a_adr), .dmem_d(a_d),
      .dmem_we(a_we), .dmem_size(a_size), .dmem_q(a_q), .dmem_ack(a_ack),
      .dmem_err(a_err), .dmem_misaligned(a_mis), .dmem_page_fault(a_pf));

   dmem_responder #(.XLEN(32), .MEM_WORDS(16), .BASE_ADDR(32'h1000), .LATENCY(3)) dut_b (
      .clk(clk), .rst(rst), .dmem_req(b_req), .dmem_adr(b_adr), .dmem_d(b_d),
      .dmem_we(b_we), .dmem_size(b_size), .dmem_q(b_q), .dmem_ack(b_ack),
      .dmem_err(b_err), .dmem_misaligned(b_mis), .dmem_page_fault(b_pf));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic we, input biu_size_t sz, input logic [31:0] adr,
                               input logic [31:0] d, input logic [2:0] res, input logic [31:0] q);
      vec_t v;
      v.we = we; v.sz = sz; v.adr = adr; v.d = d; v.res = res; v.q = q;
      return v;
   endfunction

   task automatic mon(input bit sb, input logic ack, input logic err, input logic mis,
                      input logic pf, input logic [31:0] q);
      exp_t  e;
      string p;
      int    sz;
      p  = sb ? "B" : "A";
      sz = sb ? qb.size() : qa.size();
      if (ack || err || mis) begin
         if (sz == 0) begin
            chk({p, " unexpected strobe"}, {61'd0, ack, err, mis}, 64'd0);
         end else begin
            if (sb) e = qb.pop_front();
            else    e = qa.pop_front();
            chk($sformatf("%s vec%0d strobes", p, e.tag), {61'd0, ack, err, mis}, {61'd0, e.res});
            chk($sformatf("%s vec%0d q", p, e.tag), {32'd0, q}, {32'd0, e.q});
            chk($sformatf("%s vec%0d cycle", p, e.tag), 64'(cyc), 64'(e.cyc));
         end
      end else begin
         chk({p, " idle q/page_fault"}, {31'd0, pf, q}, 64'd0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(1'b0, a_ack, a_err, a_mis, a_pf, a_q);
         mon(1'b1, b_ack, b_err, b_mis, b_pf, b_q);
      end
   end

   task automatic drain(input bit sb);
      int n = 0;
      while ((sb ? qb.size() : qa.size()) != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(sb ? "B response timeout" : "A response timeout",
          64'(sb ? qb.size() : qa.size()), 64'd0);
      if (sb) qb.delete();
      else    qa.delete();
   endtask

   task automatic txn(input bit sb, input vec_t v, input int tag);
      exp_t e;
      @(negedge clk);
      e.res = v.res; e.q = v.q; e.tag = tag;
      if (sb) begin
         b_req = 1'b1; b_we = v.we; b_size = v.sz; b_adr = v.adr; b_d = v.d;
         e.cyc = cyc + 3;
         qb.push_back(e);
      end else begin
         a_req = 1'b1; a_we = v.we; a_size = v.sz; a_adr = v.adr; a_d = v.d;
         e.cyc = cyc + 1;
         qa.push_back(e);
      end
      @(posedge clk);
      #1;
      // Disturb the inputs after the accept edge; the captured request must win.
      if (sb) begin
         b_req = 1'b0; b_adr = $urandom; b_d = $urandom; b_we = ~b_we;
         b_size = biu_size_t'($urandom_range(0, 3));
      end else begin
         a_req = 1'b0; a_adr = $urandom; a_d = $urandom; a_we = ~a_we;
         a_size = biu_size_t'($urandom_range(0, 3));
      end
      drain(sb);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      exp_t e;
      rst = 1'b1;
      a_req = 0; a_we = 0; a_size = BIU_WORD; a_adr = 0; a_d = 0;
      b_req = 0; b_we = 0; b_size = BIU_WORD; b_adr = 0; b_d = 0;

      ta.push_back(mk(1, BIU_WORD,  32'h010, 32'hDEADBEEF, R_ACK, 32'h0));
      ta.push_back(mk(0, BIU_WORD,  32'h010, 32'h0,        R_ACK, 32'hDEADBEEF));
      ta.push_back(mk(1, BIU_WORD,  32'h010, 32'h11223344, R_ACK, 32'h0));
      ta.push_back(mk(1, BIU_BYTE,  32'h013, 32'h000000AA, R_ACK, 32'h0));
      ta.push_back(mk(0, BIU_WORD,  32'h010, 32'h0,        R_ACK, 32'hAA223344));
      ta.push_back(mk(1, BIU_WORD,  32'h004, 32'hCAFEF00D, R_ACK, 32'h0));
      ta.push_back(mk(0, BIU_WORD,  32'h006, 32'h0,        R_MIS, 32'h0));
      ta.push_back(mk(1, BIU_HWORD, 32'h005, 32'h00001234, R_MIS, 32'h0));
      ta.push_back(mk(0, BIU_WORD,  32'h004, 32'h0,        R_ACK, 32'hCAFEF00D));
      ta.push_back(mk(0, BIU_WORD,  32'h100, 32'h0,        R_ERR, 32'h0));
      ta.push_back(mk(1, BIU_WORD,  32'h000, 32'h01020304, R_ACK, 32'h0));
      ta.push_back(mk(1, BIU_WORD,  32'h100, 32'hFFFFFFFF, R_ERR, 32'h0));
      ta.push_back(mk(0, BIU_WORD,  32'h000, 32'h0,        R_ACK, 32'h01020304));
      ta.push_back(mk(1, BIU_HWORD, 32'h006, 32'h0000BEEF, R_ACK, 32'h0));
      ta.push_back(mk(1, BIU_BYTE,  32'h005, 32'h0000005A, R_ACK, 32'h0));
      ta.push_back(mk(0, BIU_BYTE,  32'h005, 32'h0,        R_ACK, 32'hBEEF5A0D));
      ta.push_back(mk(0, BIU_HWORD, 32'h102, 32'h0,        R_ERR, 32'h0));
      ta.push_back(mk(0, BIU_WORD,  32'h103, 32'h0,        R_MIS, 32'h0));
      ta.push_back(mk(1, BIU_DWORD, 32'h008, 32'h12345678, R_MIS, 32'h0));
      ta.push_back(mk(1, BIU_WORD,  32'h0FC, 32'h0BADF00D, R_ACK, 32'h0));
      ta.push_back(mk(0, BIU_HWORD, 32'h0FE, 32'h0,        R_ACK, 32'h0BADF00D));

      tb_v.push_back(mk(1, BIU_WORD,  32'h1008, 32'h12345678, R_ACK, 32'h0));
      tb_v.push_back(mk(0, BIU_WORD,  32'h1008, 32'h0,        R_ACK, 32'h12345678));
      tb_v.push_back(mk(0, BIU_WORD,  32'h0FFC, 32'h0,        R_ERR, 32'h0));
      tb_v.push_back(mk(0, BIU_WORD,  32'h1040, 32'h0,        R_ERR, 32'h0));
      tb_v.push_back(mk(1, BIU_HWORD, 32'h100A, 32'h0000ABCD, R_ACK, 32'h0));
      tb_v.push_back(mk(0, BIU_WORD,  32'h1008, 32'h0,        R_ACK, 32'hABCD5678));
      tb_v.push_back(mk(1, BIU_WORD,  32'h103C, 32'h00C0FFEE, R_ACK, 32'h0));
      tb_v.push_back(mk(0, BIU_WORD,  32'h103C, 32'h0,        R_ACK, 32'h00C0FFEE));
      tb_v.push_back(mk(1, BIU_WORD,  32'h1001, 32'h55555555, R_MIS, 32'h0));

      repeat (3) @(negedge clk);
      chk("A outputs in reset", {28'd0, a_ack, a_err, a_mis, a_pf, a_q}, 64'd0);
      chk("B outputs in reset", {28'd0, b_ack, b_err, b_mis, b_pf, b_q}, 64'd0);
      rst = 1'b0;

      foreach (ta[i]) txn(1'b0, ta[i], i);

      // Write then read of the same word with req held high across both.
      @(negedge clk);
      a_req = 1; a_we = 1; a_size = BIU_WORD; a_adr = 32'h20; a_d = 32'h5555AAAA;
      e.res = R_ACK; e.q = 32'h0; e.cyc = cyc + 1; e.tag = 200; qa.push_back(e);
      e.res = R_ACK; e.q = 32'h5555AAAA; e.cyc = cyc + 3; e.tag = 201; qa.push_back(e);
      @(posedge clk); #1;
      a_we = 0; a_adr = 32'h20; a_d = 32'h0;
      @(posedge clk);
      @(posedge clk); #1;
      a_req = 0;
      drain(1'b0);

      foreach (tb_v[i]) txn(1'b1, tb_v[i], 100 + i);

      // Two reads with req held: acks 3 cycles after each accept, accepts 4 apart.
      @(negedge clk);
      b_req = 1; b_we = 0; b_size = BIU_WORD; b_adr = 32'h1008; b_d = 32'h0;
      e.res = R_ACK; e.q = 32'hABCD5678; e.cyc = cyc + 3; e.tag = 210; qb.push_back(e);
      e.res = R_ACK; e.q = 32'hABCD5678; e.cyc = cyc + 7; e.tag = 211; qb.push_back(e);
      repeat (5) @(posedge clk);
      #1 b_req = 0;
      drain(1'b1);

      // Reset while the ack is being driven clears the outputs at once.
      @(negedge clk);
      a_req = 1; a_we = 0; a_size = BIU_WORD; a_adr = 32'h10;
      @(posedge clk); #1;
      a_req = 0;
      chk("A ack before async reset", {63'd0, a_ack}, 64'd1);
      chk("A q before async reset", {32'd0, a_q}, {32'd0, 32'hAA223344});
      #1 rst = 1'b1;
      #1 chk("A outputs after async reset", {28'd0, a_ack, a_err, a_mis, a_pf, a_q}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset one cycle after a write accept abandons the write.
      @(negedge clk);
      b_req = 1; b_we = 1; b_size = BIU_WORD; b_adr = 32'h1008; b_d = 32'hFFFFFFFF;
      @(posedge clk); #1;
      b_req = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1 chk("B outputs after async reset", {28'd0, b_ack, b_err, b_mis, b_pf, b_q}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      txn(1'b1, mk(0, BIU_WORD, 32'h1008, 32'h0, R_ACK, 32'hABCD5678), 220);
      txn(1'b0, mk(0, BIU_WORD, 32'h010,  32'h0, R_ACK, 32'hAA223344), 221);

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
